// File: rtl/prng_tick_gen_if.sv
// Signal bundle between the PRNG timing front-end and its environment.
// The master side drives the enable, run switch and step button; the slave
// side (the tick generator) returns the clock enables and status.
`timescale 1ns/1ps
interface prng_tick_gen_if;
  logic       en;
  logic       mode_run;
  logic       step_btn;
  logic       slow_tick;
  logic       fast_tick;
  logic       running;
  logic [7:0] tick_count;

  modport master (
    output en,
    output mode_run,
    output step_btn,
    input  slow_tick,
    input  fast_tick,
    input  running,
    input  tick_count
  );

  modport slave (
    input  en,
    input  mode_run,
    input  step_btn,
    output slow_tick,
    output fast_tick,
    output running,
    output tick_count
  );
endinterface

// File: rtl/prng_tick_gen.sv
// PRNG timing front-end: produces single-cycle clock enables for the data
// LFSR (slow_tick) and control LFSR (fast_tick) on the one system clock.
// Supports free-run and pause modes plus a debounced single-step button;
// a step issues one pulse on both ticks while paused.
`timescale 1ns/1ps
module prng_tick_gen #(
  parameter logic [23:0] SLOW_DIV  = 24'd10_000_000,
  parameter logic [23:0] FAST_DIV  = 24'd4,
  parameter logic [19:0] DB_CYCLES = 20'd500_000
) (
  input  logic            clk,
  input  logic            reset,
  prng_tick_gen_if.slave  bus
);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        run_meta_q, run_meta_d;
  logic        run_s_q, run_s_d;
  logic        btn_meta_q, btn_meta_d;
  logic        btn_s_q, btn_s_d;
  logic [23:0] slow_cnt_q, slow_cnt_d;
  logic [23:0] fast_cnt_q, fast_cnt_d;
  logic        slow_tick_q, slow_tick_d;
  logic        fast_tick_q, fast_tick_d;
  logic        running_q, running_d;
  logic [7:0]  tick_count_q, tick_count_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        db_state_q, db_state_d;
  logic        step_pend_q, step_pend_d;

  // Two-flop synchronizers bring the raw switch and button into the clk domain.
  always_comb begin
    run_meta_d = bus.mode_run;
    run_s_d    = run_meta_q;
    btn_meta_d = bus.step_btn;
    btn_s_d    = btn_meta_q;
  end

  // Run/pause state: enter RUN only while enabled with the switch up; leave on either dropping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSED: if (bus.en && run_s_q) state_d = RUN;
      RUN:    if (!bus.en || !run_s_q) state_d = PAUSED;
      default: state_d = PAUSED;
    endcase
    running_d = (state_d == RUN);
  end

  // Debouncer: a level change is accepted only after it persists for DB_CYCLES edges; a press while paused arms one step.
  always_comb begin
    db_state_d  = db_state_q;
    db_cnt_d    = '0;
    step_pend_d = 1'b0;
    if (btn_s_q != db_state_q) begin
      if (db_cnt_q == DB_CYCLES - 20'd1) begin
        db_state_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 20'd1;
      end
    end
    step_pend_d = !db_state_q && db_state_d && (state_q == PAUSED) &&
                  !run_s_q && bus.en && (state_d == PAUSED);
  end

  // Dividers count only while staying in RUN, so each RUN entry restarts a full period; otherwise a pending step fires both ticks.
  always_comb begin
    slow_cnt_d  = '0;
    fast_cnt_d  = '0;
    slow_tick_d = 1'b0;
    fast_tick_d = 1'b0;
    if (state_q == RUN && state_d == RUN) begin
      if (slow_cnt_q == SLOW_DIV - 24'd1) begin
        slow_tick_d = 1'b1;
      end else begin
        slow_cnt_d = slow_cnt_q + 24'd1;
      end
      if (fast_cnt_q == FAST_DIV - 24'd1) begin
        fast_tick_d = 1'b1;
      end else begin
        fast_cnt_d = fast_cnt_q + 24'd1;
      end
    end else if (step_pend_q && bus.en && state_d == PAUSED) begin
      slow_tick_d = 1'b1;
      fast_tick_d = 1'b1;
    end
    tick_count_d = tick_count_q + {7'd0, slow_tick_d};
  end

  // State register for all flops; reset returns everything to idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PAUSED;
      run_meta_q   <= 1'b0;
      run_s_q      <= 1'b0;
      btn_meta_q   <= 1'b0;
      btn_s_q      <= 1'b0;
      slow_cnt_q   <= '0;
      fast_cnt_q   <= '0;
      slow_tick_q  <= 1'b0;
      fast_tick_q  <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
      db_cnt_q     <= '0;
      db_state_q   <= 1'b0;
      step_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_meta_q   <= run_meta_d;
      run_s_q      <= run_s_d;
      btn_meta_q   <= btn_meta_d;
      btn_s_q      <= btn_s_d;
      slow_cnt_q   <= slow_cnt_d;
      fast_cnt_q   <= fast_cnt_d;
      slow_tick_q  <= slow_tick_d;
      fast_tick_q  <= fast_tick_d;
      running_q    <= running_d;
      tick_count_q <= tick_count_d;
      db_cnt_q     <= db_cnt_d;
      db_state_q   <= db_state_d;
      step_pend_q  <= step_pend_d;
    end
  end

  assign bus.slow_tick  = slow_tick_q;
  assign bus.fast_tick  = fast_tick_q;
  assign bus.running    = running_q;
  assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_prng_tick_gen.sv
// Self-checking bench for prng_tick_gen with SLOW_DIV=8, FAST_DIV=2,
// DB_CYCLES=4. Expected outputs per edge are derived from the tick timing
// rules and queued; a monitor compares them on the falling edge.
`timescale 1ns/1ps
module tb_prng_tick_gen;

  localparam int NEVER = 1_000_000;

  typedef struct {
    int         at;
    logic       slow;
    logic       fast;
    logic       run;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic en;
    logic mode;
    logic btn;
    logic slow;
    logic fast;
    logic run;
  } vec_t;

  logic clk;
  logic reset;
  prng_tick_gen_if bus();

  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_cnt = 8'd0;
  string      scen = "init";
  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       tbl_step[14];
  vec_t       tbl_bounce[30];

  prng_tick_gen #(
    .SLOW_DIV  (24'd8),
    .FAST_DIV  (24'd2),
    .DB_CYCLES (20'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to timestamp scoreboard entries.
  always @(posedge clk) cyc <= cyc + 1;

  // Tick period rule: a pulse every d edges after entry e, strictly before leaving at x.
  function automatic logic divTick(input int k, input int e, input int x, input int d);
    return (k > e) && (k < x) && (((k - e) % d) == 0);
  endfunction

  function automatic logic inRun(input int k, input int e, input int x);
    return (k >= e) && (k < x);
  endfunction

  task automatic compareOut(input string name, input int at, input logic s, input logic f,
                            input logic r, input logic [7:0] c);
    tests++;
    if ({bus.slow_tick, bus.fast_tick, bus.running, bus.tick_count} !== {s, f, r, c}) begin
      fails++;
      $display("[TB] FAIL %s edge=%0d: got slow=%0b fast=%0b run=%0b cnt=%0d, expected slow=%0b fast=%0b run=%0b cnt=%0d",
               name, at, bus.slow_tick, bus.fast_tick, bus.running, bus.tick_count, s, f, r, c);
    end
  endtask

  task automatic checkOutput(input string name, input logic s, input logic f,
                             input logic r, input logic [7:0] c);
    compareOut(name, cyc, s, f, r, c);
  endtask

  // Drive inputs for the next edge and queue what the outputs must be after it.
  task automatic applyStimulus(input logic en, input logic mode, input logic btn,
                               input logic s, input logic f, input logic r);
    bus.en       = en;
    bus.mode_run = mode;
    bus.step_btn = btn;
    if (s) exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{at: cyc + 1, slow: s, fast: f, run: r, cnt: exp_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s drain: got %0d pending entries, expected 0", scen, sb.size());
      sb.delete();
    end
  endtask

  task automatic doReset();
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.mode_run = 1'b0;
    bus.step_btn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 8'd0;
  endtask

  // Scoreboard monitor: compare queued expectations on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at < cyc) begin
        tests++;
        fails++;
        $display("[TB] FAIL %s sb_late: got compare at edge %0d, expected edge %0d", scen, cyc, mon_e.at);
      end else begin
        compareOut(scen, mon_e.at, mon_e.slow, mon_e.fast, mon_e.run, mon_e.cnt);
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Vector tables: single clean press, and bouncing button then stable press.
    for (int k = 1; k <= 14; k++)
      tbl_step[k-1] = '{en: 1'b1, mode: 1'b0, btn: 1'b1,
                        slow: (k == 7), fast: (k == 7), run: 1'b0};
    for (int k = 1; k <= 30; k++)
      tbl_bounce[k-1] = '{en: 1'b1, mode: 1'b0,
                          btn: (k <= 20) ? ((((k - 1) / 2) % 2) == 0) : 1'b1,
                          slow: (k == 27), fast: (k == 27), run: 1'b0};

    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.mode_run = 1'b0;
    bus.step_btn = 1'b0;

    // Free run from reset: RUN at edge 3, fast at 5,7,..., slow at 11,19,27.
    scen = "s1_freerun";
    doReset();
    for (int k = 1; k <= 28; k++)
      applyStimulus(1'b1, 1'b1, 1'b0, divTick(k, 3, NEVER, 8), divTick(k, 3, NEVER, 2),
                    inRun(k, 3, NEVER));
    waitDrain();

    // Pause mid-period then resume: a full period follows re-entry.
    scen = "s2_pause_resume";
    doReset();
    for (int k = 1; k <= 34; k++)
      applyStimulus(1'b1, (k <= 13) || (k >= 21), 1'b0,
                    divTick(k, 3, 16, 8) | divTick(k, 23, NEVER, 8),
                    divTick(k, 3, 16, 2) | divTick(k, 23, NEVER, 2),
                    inRun(k, 3, 16) | inRun(k, 23, NEVER));
    waitDrain();

    // Clean press while paused: one pulse on both ticks after edge 7.
    scen = "s3_step";
    doReset();
    for (int i = 0; i < 14; i++)
      applyStimulus(tbl_step[i].en, tbl_step[i].mode, tbl_step[i].btn,
                    tbl_step[i].slow, tbl_step[i].fast, tbl_step[i].run);
    waitDrain();

    // Bouncing button: nothing while bouncing, one pulse 7 edges after stable rise.
    scen = "s4_bounce";
    doReset();
    for (int i = 0; i < 30; i++)
      applyStimulus(tbl_bounce[i].en, tbl_bounce[i].mode, tbl_bounce[i].btn,
                    tbl_bounce[i].slow, tbl_bounce[i].fast, tbl_bounce[i].run);
    waitDrain();

    // Count wrap after 256 slow ticks, step ignored in RUN, en=0 stops ticks next edge.
    scen = "s5_wrap_en";
    doReset();
    for (int k = 1; k <= 2070; k++)
      applyStimulus(k <= 2060, 1'b1, k >= 2052, divTick(k, 3, 2061, 8),
                    divTick(k, 3, 2061, 2), inRun(k, 3, 2061));
    waitDrain();

    // Async reset between edges mid-debounce with slow_tick high.
    scen = "s6_async_reset";
    doReset();
    for (int k = 1; k <= 11; k++)
      applyStimulus(1'b1, 1'b1, k >= 9, divTick(k, 3, NEVER, 8), divTick(k, 3, NEVER, 2),
                    inRun(k, 3, NEVER));
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 8'd0;
    for (int k = 1; k <= 10; k++)
      applyStimulus(1'b1, 1'b0, 1'b1, k == 7, k == 7, 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
